// File: rtl/ula_seq_arbiter.sv
// ula_seq_arbiter: round-robin arbiter that time-shares an external 2-bit ULA
// slice between two requesters. Each granted WIDTH-bit add runs LSB-first,
// one 2-bit digit per cycle, with the inter-digit carry held in carry_q.
module ula_seq_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic             req_cin0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic             req_cin1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             busy,
    output logic [1:0]       ula_a,
    output logic [1:0]       ula_b,
    output logic [1:0]       ula_cin,
    input  logic [1:0]       ula_sum,
    input  logic [1:0]       ula_cout
);

    localparam int DIGITS = WIDTH / 2;
    localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [KW-1:0]    k;
    logic             owner;
    logic             rr_last;
    logic             grant_id;
    logic [WIDTH+1:0] sum_ext;

    // Pick the winner: on a tie the requester that did not win last time.
    always_comb begin
        grant_id = req[1];
        if (req == 2'b11) begin
            grant_id = ~rr_last;
        end
    end

    // Grant is a same-cycle pulse so operands are captured on this edge.
    assign gnt = (state == IDLE && req != 2'b00) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

    assign busy = (state != IDLE);

    // Operands shift right each digit, so the current digit is always bits [1:0].
    assign ula_a   = (state == RUN) ? a_q[1:0] : 2'b00;
    assign ula_b   = (state == RUN) ? b_q[1:0] : 2'b00;
    assign ula_cin = {ula_cout[0], (state == RUN) & carry_q};

    // New digit enters at the top; after DIGITS shifts digit k sits at [2k+1:2k].
    assign sum_ext = {ula_sum, sum_q};

    // Control FSM, operand/sum shift registers and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            k        <= '0;
            owner    <= 1'b0;
            rr_last  <= 1'b1;
            done     <= '0;
            res_sum  <= '0;
            res_cout <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        owner   <= grant_id;
                        rr_last <= grant_id;
                        a_q     <= grant_id ? req_a1 : req_a0;
                        b_q     <= grant_id ? req_b1 : req_b0;
                        carry_q <= grant_id ? req_cin1 : req_cin0;
                        k       <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 2;
                    b_q     <= b_q >> 2;
                    sum_q   <= sum_ext[WIDTH+1:2];
                    carry_q <= ula_cout[1];
                    k       <= k + 1'b1;
                    if (k == K_LAST) begin
                        // Results load on the last digit edge so they are
                        // already valid in the cycle done is high.
                        state    <= DONE;
                        done     <= owner ? 2'b10 : 2'b01;
                        res_sum  <= sum_ext[WIDTH+1:2];
                        res_cout <= ula_cout[1];
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_seq_arbiter.sv
// tb_ula_seq_arbiter: self-checking bench for ula_seq_arbiter with WIDTH=8 and
// WIDTH=2 instances, each wired to a behavioural 2-lane full-adder ULA.
module tb_ula_seq_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // ---------------- WIDTH=8 instance ----------------
    logic [1:0] req8, gnt8, done8, ua8, ub8, uc8, us8, uco8;
    logic [7:0] a0_8, b0_8, a1_8, b1_8, sum8;
    logic       cin0_8, cin1_8, cout8, busy8;

    ula_seq_arbiter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .req(req8),
        .req_a0(a0_8), .req_b0(b0_8), .req_cin0(cin0_8),
        .req_a1(a1_8), .req_b1(b1_8), .req_cin1(cin1_8),
        .gnt(gnt8), .done(done8), .res_sum(sum8), .res_cout(cout8), .busy(busy8),
        .ula_a(ua8), .ula_b(ub8), .ula_cin(uc8), .ula_sum(us8), .ula_cout(uco8)
    );

    assign {uco8[0], us8[0]} = 2'(ua8[0]) + 2'(ub8[0]) + 2'(uc8[0]);
    assign {uco8[1], us8[1]} = 2'(ua8[1]) + 2'(ub8[1]) + 2'(uc8[1]);

    // ---------------- WIDTH=2 instance ----------------
    logic [1:0] req2, gnt2, done2, ua2, ub2, uc2, us2, uco2;
    logic [1:0] a0_2, b0_2, a1_2, b1_2, sum2;
    logic       cin0_2, cin1_2, cout2, busy2;

    ula_seq_arbiter #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2),
        .req_a0(a0_2), .req_b0(b0_2), .req_cin0(cin0_2),
        .req_a1(a1_2), .req_b1(b1_2), .req_cin1(cin1_2),
        .gnt(gnt2), .done(done2), .res_sum(sum2), .res_cout(cout2), .busy(busy2),
        .ula_a(ua2), .ula_b(ub2), .ula_cin(uc2), .ula_sum(us2), .ula_cout(uco2)
    );

    assign {uco2[0], us2[0]} = 2'(ua2[0]) + 2'(ub2[0]) + 2'(uc2[0]);
    assign {uco2[1], us2[1]} = 2'(ua2[1]) + 2'(ub2[1]) + 2'(uc2[1]);

    // Drives one request on the WIDTH=8 instance and reports what happened.
    task automatic do_op8(input logic id, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, output logic [1:0] g, output int lat,
                          output logic [1:0] d, output logic [7:0] s, output logic co);
        if (id) begin a1_8 = a; b1_8 = b; cin1_8 = cin; req8 = 2'b10; end
        else    begin a0_8 = a; b0_8 = b; cin0_8 = cin; req8 = 2'b01; end
        @(negedge clk);
        g = gnt8;
        @(posedge clk); #1;
        req8 = 2'b00;
        a0_8 = 8'($urandom); b0_8 = 8'($urandom); cin0_8 = 1'($urandom);
        a1_8 = 8'($urandom); b1_8 = 8'($urandom); cin1_8 = 1'($urandom);
        lat = -1; d = '0; s = '0; co = 1'b0;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (done8 != 2'b00) begin
                lat = i; d = done8; s = sum8; co = cout8;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (gnt8 !== 2'b00) begin n_fail++; $display("FAIL reset_gnt8: got %b expected 00", gnt8); end
        n_checks++; if (done8 !== 2'b00) begin n_fail++; $display("FAIL reset_done8: got %b expected 00", done8); end
        n_checks++; if ({cout8, sum8} !== 9'h000) begin n_fail++; $display("FAIL reset_res8: got %h expected 000", {cout8, sum8}); end
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy8: got %b expected 0", busy8); end
        n_checks++; if ({ua8, ub8, uc8[0]} !== 5'b0) begin n_fail++; $display("FAIL reset_ula8: got %b expected 00000", {ua8, ub8, uc8[0]}); end
        n_checks++; if ({gnt2, done2, busy2, cout2, sum2} !== 8'h00) begin n_fail++; $display("FAIL reset_w2: got %h expected 00", {gnt2, done2, busy2, cout2, sum2}); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [1:0] g, d; logic [7:0] s; logic co; int lat;
        do_op8(1'b0, 8'hFF, 8'h01, 1'b0, g, lat, d, s, co);
        n_checks++; if (g !== 2'b01) begin n_fail++; $display("FAIL basic1_gnt: got %b expected 01", g); end
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL basic1_latency: got %0d expected 5", lat); end
        n_checks++; if (d !== 2'b01) begin n_fail++; $display("FAIL basic1_done: got %b expected 01", d); end
        n_checks++; if ({co, s} !== 9'h100) begin n_fail++; $display("FAIL basic1_result: got %h expected 100", {co, s}); end
        do_op8(1'b1, 8'h7F, 8'h80, 1'b1, g, lat, d, s, co);
        n_checks++; if (g !== 2'b10) begin n_fail++; $display("FAIL basic2_gnt: got %b expected 10", g); end
        n_checks++; if (lat !== 5 || d !== 2'b10) begin n_fail++; $display("FAIL basic2_done: got %0d/%b expected 5/10", lat, d); end
        n_checks++; if ({co, s} !== 9'h100) begin n_fail++; $display("FAIL basic2_result: got %h expected 100", {co, s}); end
        do_op8(1'b1, 8'h12, 8'h34, 1'b0, g, lat, d, s, co);
        n_checks++; if (lat !== 5 || d !== 2'b10) begin n_fail++; $display("FAIL basic3_done: got %0d/%b expected 5/10", lat, d); end
        n_checks++; if ({co, s} !== 9'h046) begin n_fail++; $display("FAIL basic3_result: got %h expected 046", {co, s}); end
        // Results hold after done
        @(negedge clk);
        n_checks++; if ({cout8, sum8} !== 9'h046) begin n_fail++; $display("FAIL basic3_hold: got %h expected 046", {cout8, sum8}); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g, exp_d;
        int slot;
        rst = 1'b1;
        req8 = 2'b11;
        a0_8 = 8'h10; b0_8 = 8'h20; cin0_8 = 1'b1;
        a1_8 = 8'hF0; b1_8 = 8'h20; cin1_8 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 24; c++) begin
            slot  = c / 6;
            exp_g = (c % 6 == 0) ? ((slot % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_d = (c % 6 == 5) ? ((slot % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            @(negedge clk);
            n_checks++; if (gnt8 !== exp_g) begin n_fail++; $display("FAIL rr_gnt c=%0d: got %b expected %b", c, gnt8, exp_g); end
            n_checks++; if (done8 !== exp_d) begin n_fail++; $display("FAIL rr_done c=%0d: got %b expected %b", c, done8, exp_d); end
            if (c % 6 == 5) begin
                n_checks++;
                if ({cout8, sum8} !== ((slot % 2 == 0) ? 9'h031 : 9'h110)) begin
                    n_fail++; $display("FAIL rr_result c=%0d: got %h expected %h", c, {cout8, sum8}, (slot % 2 == 0) ? 9'h031 : 9'h110);
                end
            end
            @(posedge clk); #1;
        end
        req8 = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        logic seen;
        req8 = 2'b01; a0_8 = 8'hAA; b0_8 = 8'h11; cin0_8 = 1'b0;
        @(posedge clk); #1;
        req8 = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++; if ({gnt8, done8, busy8} !== 5'b0) begin n_fail++; $display("FAIL abort_ctrl: got %b expected 00000", {gnt8, done8, busy8}); end
        n_checks++; if ({cout8, sum8} !== 9'h000) begin n_fail++; $display("FAIL abort_res: got %h expected 000", {cout8, sum8}); end
        n_checks++; if ({ua8, ub8} !== 4'b0) begin n_fail++; $display("FAIL abort_ula: got %b expected 0000", {ua8, ub8}); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done8 !== 2'b00) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b expected 0", seen); end
        @(posedge clk); #1;
        rst = 1'b0;
        req8 = 2'b11;
        a0_8 = 8'h01; b0_8 = 8'h02; cin0_8 = 1'b0;
        @(negedge clk);
        n_checks++; if (gnt8 !== 2'b01) begin n_fail++; $display("FAIL abort_tie_gnt: got %b expected 01", gnt8); end
        @(posedge clk); #1;
        req8 = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (done8 != 2'b00) begin
                seen = 1'b1;
                n_checks++; if ({done8, cout8, sum8} !== {2'b01, 9'h003}) begin n_fail++; $display("FAIL abort_after_op: got %h expected %h", {done8, cout8, sum8}, {2'b01, 9'h003}); end
            end
            @(posedge clk); #1;
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL abort_after_timeout: got %b expected 1", seen); end
        @(posedge clk); #1;
    endtask

    task automatic test_drop();
        req8 = 2'b01; a0_8 = 8'h0F; b0_8 = 8'h01; cin0_8 = 1'b0;
        a1_8 = 8'h55; b1_8 = 8'h55; cin1_8 = 1'b1;
        @(negedge clk);
        n_checks++; if (gnt8 !== 2'b01) begin n_fail++; $display("FAIL drop_gnt0: got %b expected 01", gnt8); end
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk); #1;
            req8 = (j == 2) ? 2'b10 : 2'b00;
            @(negedge clk);
            n_checks++; if (gnt8 !== 2'b00) begin n_fail++; $display("FAIL drop_no_gnt j=%0d: got %b expected 00", j, gnt8); end
            if (j == 2) begin
                n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL drop_busy: got %b expected 1", busy8); end
            end
            if (j == 5) begin
                n_checks++; if ({done8, cout8, sum8} !== {2'b01, 9'h010}) begin n_fail++; $display("FAIL drop_done: got %h expected %h", {done8, cout8, sum8}, {2'b01, 9'h010}); end
            end
        end
        @(posedge clk); #1;
        req8 = 2'b11;
        @(negedge clk);
        n_checks++; if (gnt8 !== 2'b10) begin n_fail++; $display("FAIL drop_rr_kept: got %b expected 10", gnt8); end
        @(posedge clk); #1;
        req8 = 2'b00;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_random_w8();
        logic [1:0] pend, exp_g, exp_d;
        logic [7:0] ra[2], rb[2];
        logic       rc[2];
        logic       rr, owner, gid;
        logic [8:0] val;
        int         free_c, due, ops, c;
        rst = 1'b1; req8 = 2'b00; req2 = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        pend = '0; rr = 1'b1; owner = 1'b0; val = '0; free_c = 0; due = -1; ops = 0; c = 0;
        for (int i = 0; i < 2; i++) begin ra[i] = '0; rb[i] = '0; rc[i] = 1'b0; end
        while ((ops < 1000 || c <= due) && c < 20000) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ops < 1000 && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1; ra[i] = 8'($urandom); rb[i] = 8'($urandom); rc[i] = 1'($urandom);
                end
            end
            req8 = pend;
            a0_8 = ra[0]; b0_8 = rb[0]; cin0_8 = rc[0];
            a1_8 = ra[1]; b1_8 = rb[1]; cin1_8 = rc[1];
            @(negedge clk);
            exp_d = (c == due) ? (owner ? 2'b10 : 2'b01) : 2'b00;
            n_checks++; if (done8 !== exp_d) begin n_fail++; $display("FAIL rand8_done c=%0d: got %b expected %b", c, done8, exp_d); end
            if (c == due) begin
                n_checks++; if ({cout8, sum8} !== val) begin n_fail++; $display("FAIL rand8_result c=%0d: got %h expected %h", c, {cout8, sum8}, val); end
            end
            exp_g = 2'b00;
            if (c >= free_c && pend != 2'b00) begin
                gid    = (pend == 2'b11) ? ~rr : pend[1];
                exp_g  = gid ? 2'b10 : 2'b01;
                rr     = gid;
                owner  = gid;
                val    = 9'(ra[gid]) + 9'(rb[gid]) + 9'(rc[gid]);
                free_c = c + 6;
                due    = c + 5;
                pend[gid] = 1'b0;
                ops++;
            end
            n_checks++; if (gnt8 !== exp_g) begin n_fail++; $display("FAIL rand8_gnt c=%0d: got %b expected %b", c, gnt8, exp_g); end
            @(posedge clk); #1;
            c++;
        end
        n_checks++; if (c >= 20000) begin n_fail++; $display("FAIL rand8_timeout: got %0d ops expected 1000", ops); end
        req8 = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_random_w2();
        logic [1:0] pend, exp_g, exp_d;
        logic [1:0] ra[2], rb[2];
        logic       rc[2];
        logic       rr, owner, gid;
        logic [2:0] val;
        int         free_c, due, ops, c;
        rst = 1'b1; req8 = 2'b00; req2 = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        pend = '0; rr = 1'b1; owner = 1'b0; val = '0; free_c = 0; due = -1; ops = 0; c = 0;
        for (int i = 0; i < 2; i++) begin ra[i] = '0; rb[i] = '0; rc[i] = 1'b0; end
        while ((ops < 1000 || c <= due) && c < 20000) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ops < 1000 && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1; ra[i] = 2'($urandom); rb[i] = 2'($urandom); rc[i] = 1'($urandom);
                end
            end
            req2 = pend;
            a0_2 = ra[0]; b0_2 = rb[0]; cin0_2 = rc[0];
            a1_2 = ra[1]; b1_2 = rb[1]; cin1_2 = rc[1];
            @(negedge clk);
            exp_d = (c == due) ? (owner ? 2'b10 : 2'b01) : 2'b00;
            n_checks++; if (done2 !== exp_d) begin n_fail++; $display("FAIL rand2_done c=%0d: got %b expected %b", c, done2, exp_d); end
            if (c == due) begin
                n_checks++; if ({cout2, sum2} !== val) begin n_fail++; $display("FAIL rand2_result c=%0d: got %h expected %h", c, {cout2, sum2}, val); end
            end
            exp_g = 2'b00;
            if (c >= free_c && pend != 2'b00) begin
                gid    = (pend == 2'b11) ? ~rr : pend[1];
                exp_g  = gid ? 2'b10 : 2'b01;
                rr     = gid;
                owner  = gid;
                val    = 3'(ra[gid]) + 3'(rb[gid]) + 3'(rc[gid]);
                free_c = c + 3;
                due    = c + 2;
                pend[gid] = 1'b0;
                ops++;
            end
            n_checks++; if (gnt2 !== exp_g) begin n_fail++; $display("FAIL rand2_gnt c=%0d: got %b expected %b", c, gnt2, exp_g); end
            @(posedge clk); #1;
            c++;
        end
        n_checks++; if (c >= 20000) begin n_fail++; $display("FAIL rand2_timeout: got %0d ops expected 1000", ops); end
        req2 = 2'b00;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        req8 = 2'b00; a0_8 = '0; b0_8 = '0; cin0_8 = 1'b0; a1_8 = '0; b1_8 = '0; cin1_8 = 1'b0;
        req2 = 2'b00; a0_2 = '0; b0_2 = '0; cin0_2 = 1'b0; a1_2 = '0; b1_2 = '0; cin1_2 = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_reset_abort();
        test_drop();
        test_random_w8();
        test_random_w2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before 1000000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
